// File: rtl/sram_uart_dumper_if.sv
// Bus bundle between the SRAM dump engine and its host / SRAM controller.
// The master modport is the dumper's view; slave is the top level's view.
interface sram_uart_dumper_if #(
  parameter int ADDR_W = 18
);
  logic              Start;
  logic [ADDR_W-1:0] Base_address;
  logic [ADDR_W-1:0] Word_count;
  logic [ADDR_W-1:0] SRAM_address;
  logic [15:0]       SRAM_read_data;
  logic              SRAM_we_n;
  logic              UART_TX_O;
  logic              Busy;
  logic              Done;

  modport master (
    input  Start, Base_address, Word_count, SRAM_read_data,
    output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

  modport slave (
    output Start, Base_address, Word_count, SRAM_read_data,
    input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );
endinterface

// File: rtl/sram_uart_dumper.sv
// Streams a contiguous SRAM word region out over an 8N1 UART, high byte
// first. Each word is read with a fixed 2-cycle SRAM latency, then sent as
// two back-to-back frames with no idle gap between them.
module sram_uart_dumper #(
  parameter int BAUD_DIV = 434,
  parameter int ADDR_W   = 18
) (
  input logic                Clock_50,
  input logic                Resetn,
  sram_uart_dumper_if.master bus
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_DUMP_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT1,
    S_RD_WAIT2,
    S_TX_HI,
    S_TX_LO,
    S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       word_buf_q, word_buf_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        tx_byte;

  // Byte currently being shifted out, selected by which half of the word is active.
  always_comb begin
    tx_byte = (state_q == S_TX_HI) ? word_buf_q[15:8] : word_buf_q[7:0];
  end

  // Next-state and output logic for the read/transmit sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    sram_addr_d = sram_addr_q;
    word_buf_d  = word_buf_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_DUMP_IDLE: begin
        tx_d = 1'b1;
        if (bus.Start) begin
          cur_addr_d  = bus.Base_address;
          remaining_d = bus.Word_count;
          if (bus.Word_count == '0) begin
            // Empty request: acknowledge immediately, never touch the bus.
            done_d = 1'b1;
          end else begin
            busy_d      = 1'b1;
            sram_addr_d = bus.Base_address;
            state_d     = S_RD_ISSUE;
          end
        end
      end

      S_RD_ISSUE: state_d = S_RD_WAIT1;

      S_RD_WAIT1: state_d = S_RD_WAIT2;

      S_RD_WAIT2: begin
        // Read data is valid now, two cycles after the address went out.
        word_buf_d = bus.SRAM_read_data;
        state_d    = S_TX_HI;
        tx_d       = 1'b0;
        baud_d     = '0;
        bit_idx_d  = '0;
      end

      S_TX_HI, S_TX_LO: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx_q == 4'd9) begin
            // Stop bit finished: chain the low byte, or close out the word.
            bit_idx_d = '0;
            if (state_q == S_TX_HI) begin
              state_d = S_TX_LO;
              tx_d    = 1'b0;
            end else begin
              state_d = S_NEXT;
              tx_d    = 1'b1;
              if (remaining_q == ADDR_W'(1)) begin
                done_d = 1'b1;
                busy_d = 1'b0;
              end
            end
          end else begin
            // Index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : tx_byte[bit_idx_q[2:0]];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      S_NEXT: begin
        cur_addr_d  = cur_addr_q + ADDR_W'(1);
        remaining_d = remaining_q - ADDR_W'(1);
        if (remaining_q == ADDR_W'(1)) begin
          state_d = S_DUMP_IDLE;
        end else begin
          sram_addr_d = cur_addr_q + ADDR_W'(1);
          state_d     = S_RD_ISSUE;
        end
      end

      default: state_d = S_DUMP_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock_50) begin
    // NOTE: reset is sampled on the clock edge, so it belongs inside the
    // clocked block rather than in the sensitivity list.
    if (!Resetn) begin
      state_q     <= S_DUMP_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      sram_addr_q <= '0;
      word_buf_q  <= '0;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      sram_addr_q <= sram_addr_d;
      word_buf_q  <= word_buf_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.SRAM_address = sram_addr_q;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.UART_TX_O    = tx_q;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;

endmodule
